// File: rtl/fifo_pdata_unpack.sv
// Word-in / byte-out buffer: 32-bit pixel words are stored, then serialised
// one byte per clock through a single output stage register.
module fifo_pdata_unpack #(
    parameter int AW        = 6,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wvalid,
    output logic          wready,
    input  logic [31:0]   wdata,
    output logic          rvalid,
    input  logic          rready,
    output logic [7:0]    rdata,
    output logic          rlast,
    output logic [AW:0]   level,
    output logic          empty
);

    localparam int          DEPTH      = 1 << AW;
    localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};

    // valid/ready: a beat moves on a clock edge where valid && ready are both
    // high; the sender holds its data steady while valid is high and ready low.

    logic [31:0] mem [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [31:0] sword_q, sword_d;
    logic        svalid_q, svalid_d;
    logic [1:0]  bsel_q, bsel_d;

    logic        full;
    logic        push;
    logic        pop;
    logic        take;
    logic [1:0]  obyte;

    assign level  = wr_ptr_q - rd_ptr_q;
    assign full   = (level == FULL_LEVEL);
    assign empty  = (level == '0);
    assign wready = !full;
    assign push   = wvalid && wready;
    assign take   = svalid_q && rready;
    // Refill the stage when it is idle or its last byte leaves this cycle.
    assign pop    = !empty && (!svalid_q || (rready && bsel_q == 2'd3));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sword_d  = sword_q;
        svalid_d = svalid_q;
        bsel_d   = bsel_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (take) begin
            if (bsel_q != 2'd3) begin
                bsel_d = bsel_q + 2'd1;
            end else begin
                svalid_d = 1'b0;
                bsel_d   = 2'd0;
            end
        end

        if (pop) begin
            sword_d  = mem[rd_ptr_q[AW-1:0]];
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            svalid_d = 1'b1;
            bsel_d   = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sword_q  <= '0;
            svalid_q <= 1'b0;
            bsel_q   <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sword_q  <= sword_d;
            svalid_q <= svalid_d;
            bsel_q   <= bsel_d;
        end
    end

    // Storage has no reset; a write during reset is dropped.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign obyte  = MSB_FIRST ? (2'd3 - bsel_q) : bsel_q;
    assign rvalid = svalid_q;
    assign rdata  = sword_q[{obyte, 3'b000} +: 8];
    assign rlast  = svalid_q && (bsel_q == 2'd3);

endmodule

// File: tb/tb_fifo_pdata_unpack.sv
// Bench for fifo_pdata_unpack: LSB-first and MSB-first instances share stimulus
// and are checked against a queue-level model plus directed literal checks.
module tb_fifo_pdata_unpack;

    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        wvalid;
    logic        rready;
    logic [31:0] wdata;

    logic        wready,   rvalid,   rlast,   empty;
    logic [7:0]  rdata;
    logic [AW:0] level;
    logic        wready_m, rvalid_m, rlast_m, empty_m;
    logic [7:0]  rdata_m;
    logic [AW:0] level_m;

    int total = 0;
    int bad   = 0;

    fifo_pdata_unpack #(.AW(AW), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
        .level(level), .empty(empty)
    );

    fifo_pdata_unpack #(.AW(AW), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .wvalid(wvalid), .wready(wready_m), .wdata(wdata),
        .rvalid(rvalid_m), .rready(rready), .rdata(rdata_m), .rlast(rlast_m),
        .level(level_m), .empty(empty_m)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // model: words waiting in storage, the word being serialised, and the byte stream
    logic [31:0] mq[$];
    logic [7:0]  exp_q[$];
    bit          m_init = 1'b0;
    bit          m_sv;
    logic [31:0] m_word;
    int          m_idx;
    bit          m_acc, m_refill, m_done;
    int          xfer_cnt = 0;
    logic [7:0]  sb_byte;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_sv   = 1'b0;
            m_word = '0;
            m_idx  = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            m_acc    = wvalid && (mq.size() < DEPTH);
            m_done   = m_sv && rready && (m_idx == 3);
            m_refill = (mq.size() > 0) && (!m_sv || m_done);
            if (m_sv && rready) begin
                if (m_idx == 3) begin
                    m_sv  = 1'b0;
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
            if (m_refill) begin
                m_word = mq.pop_front();
                m_sv   = 1'b1;
                m_idx  = 0;
            end
            if (m_acc) begin
                mq.push_back(wdata);
                for (int i = 0; i < 4; i++) exp_q.push_back(wdata[8*i +: 8]);
            end
        end
    end

    // scoreboard / compare process
    always @(negedge clk) begin
        if (m_init) begin
            chk("rvalid",   rvalid,   m_sv);
            chk("rlast",    rlast,    m_sv && m_idx == 3);
            chk("level",    level,    mq.size());
            chk("empty",    empty,    mq.size() == 0);
            chk("wready",   wready,   mq.size() < DEPTH);
            chk("rvalid_m", rvalid_m, m_sv);
            chk("rlast_m",  rlast_m,  m_sv && m_idx == 3);
            chk("level_m",  level_m,  mq.size());
            chk("wready_m", wready_m, mq.size() < DEPTH);
            if (m_sv) begin
                chk("rdata",   rdata,   m_word[8*m_idx +: 8]);
                chk("rdata_m", rdata_m, m_word[8*(3-m_idx) +: 8]);
            end
            if (!rst && rvalid && rready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra: got byte %0h want none", rdata);
                end else begin
                    sb_byte = exp_q.pop_front();
                    chk("sb_byte", rdata, sb_byte);
                end
            end
        end
    end

    logic [7:0]  t1_lsb [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0]  t1_msb [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    logic [31:0] t3_w   [3] = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0};
    int  cnt, first, last, nlast, peak, accepted, cyc, x0;
    bit  drained, wr_ok;

    initial begin
        rst    = 1'b1;
        wvalid = 1'b0;
        rready = 1'b0;
        wdata  = '0;
        tick();
        tick();
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata",  rdata,  8'h00);
        chk("rst_rlast",  rlast,  1'b0);
        chk("rst_level",  level,  0);
        chk("rst_empty",  empty,  1'b1);
        chk("rst_wready", wready, 1'b1);

        // single word, latency and byte order
        rst    = 1'b0;
        rready = 1'b1;
        wvalid = 1'b1;
        wdata  = 32'h44332211;
        tick();
        wvalid = 1'b0;
        wdata  = '0;
        chk("t1_rvalid_early", rvalid, 1'b0);
        chk("t1_level_early",  level,  1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_rvalid", rvalid,   1'b1);
            chk("t1_byte",   rdata,    t1_lsb[i]);
            chk("t1_rlast",  rlast,    i == 3);
            chk("t1_byte_m", rdata_m,  t1_msb[i]);
            chk("t1_rlast_m", rlast_m, i == 3);
        end
        tick();
        chk("t1_rvalid_end", rvalid, 1'b0);

        // three back-to-back words
        cnt = 0; first = -1; last = -1; nlast = 0; peak = 0;
        for (int i = 0; i < 18; i++) begin
            wvalid = (i < 3);
            wdata  = (i < 3) ? t3_w[i] : 32'h0;
            tick();
            if (rvalid) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
            if (rlast) nlast++;
            if (int'(level) > peak) peak = int'(level);
        end
        chk("t3_bytes",   cnt,  12);
        chk("t3_span",    last - first + 1, 12);
        chk("t3_rlasts",  nlast, 3);
        chk("t3_peak",    peak, 2);

        // fill with output stalled, then drain
        rready = 1'b0;
        for (int i = 0; i < 65; i++) begin
            wvalid = 1'b1;
            wdata  = 32'h7E7E7E00 + i + 1;
            tick();
        end
        chk("t4_level_full",  level,  64);
        chk("t4_wready_full", wready, 1'b0);
        chk("t4_stage_byte",  rdata,  8'h01);
        for (int i = 0; i < 3; i++) begin
            wdata = 32'hDEADBEEF;
            tick();
        end
        chk("t4_level_drop", level, 64);
        wvalid  = 1'b0;
        rready  = 1'b1;
        x0      = xfer_cnt;
        drained = 1'b0;
        for (int i = 0; i < 400 && !drained; i++) begin
            tick();
            if (!rvalid && empty) drained = 1'b1;
        end
        chk("t4_drained", drained, 1'b1);
        chk("t4_bytes",   xfer_cnt - x0, 260);

        // random stalls, continuous writes
        accepted = 0;
        cyc      = 0;
        while (accepted < 1000 && cyc < 20000) begin
            wvalid = 1'b1;
            wdata  = $urandom;
            rready = ($urandom_range(0, 3) != 0);
            wr_ok  = wready;
            tick();
            if (wr_ok) accepted++;
            cyc++;
        end
        chk("t5_words", accepted, 1000);
        wvalid  = 1'b0;
        rready  = 1'b1;
        drained = 1'b0;
        for (int i = 0; i < 5000 && !drained; i++) begin
            tick();
            if (!rvalid && empty) drained = 1'b1;
        end
        chk("t5_drained", drained, 1'b1);

        // reset mid-word
        rready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wvalid = 1'b1;
            wdata  = 32'h60000000 + i;
            tick();
        end
        wvalid = 1'b0;
        rready = 1'b1;
        tick();
        tick();
        chk("t6_level_pre", level, 5);
        rst    = 1'b1;
        rready = 1'b0;
        wvalid = 1'b1;
        wdata  = 32'hFFFFFFFF;
        tick();
        chk("t6_rvalid", rvalid, 1'b0);
        chk("t6_rlast",  rlast,  1'b0);
        chk("t6_level",  level,  0);
        chk("t6_empty",  empty,  1'b1);
        chk("t6_wready", wready, 1'b1);
        rst    = 1'b0;
        rready = 1'b1;
        wdata  = 32'hDDCCBBAA;
        tick();
        wvalid = 1'b0;
        tick();
        chk("t6_first_valid", rvalid, 1'b1);
        chk("t6_first_byte",  rdata,  8'hAA);
        tick();
        chk("t6_second_byte", rdata,  8'hBB);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_rvalid_end", rvalid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
